// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared definitions for the weight fetch sequencer and the tile scheduler.
// States: IDLE idle | REQ issuing reads | DRAIN awaiting data | DONE done pulse | FLUSH abort drain
package weight_fetch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  function automatic int unsigned wfc_byte_stride(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wfc_outstanding_tracker.sv
// Request/response counters for the weight fetch; outstanding is their CW-bit difference.
module wfc_outstanding_tracker #(
  parameter int CW              = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          accept,
  input  logic          response,
  output logic [CW-1:0] req_cnt,
  output logic [CW-1:0] rsp_cnt,
  output logic [CW-1:0] outstanding,
  output logic          limit_hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else if (clear) begin
      req_cnt <= '0;
      rsp_cnt <= '0;
    end else begin
      if (accept)   req_cnt <= req_cnt + 1'b1;
      if (response) rsp_cnt <= rsp_cnt + 1'b1;
    end
  end

  assign outstanding = req_cnt - rsp_cnt;
  assign limit_hit   = (outstanding >= CW'(MAX_OUTSTANDING));

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight-buffer fill sequencer: single-word Avalon-MM reads written to consecutive buffer slots.
// Optional fetch cycle counter (perf_cycles) is built when WFC_PERF_CNT_EN is defined.
module weight_fetch_ctrl
  import weight_fetch_ctrl_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int CW              = 16,
  parameter int WEIGHT_NUM      = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clean,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] avm_address,
  output logic          avm_read,
  input  logic          avm_waitrequest,
  input  logic [DW-1:0] avm_readdata,
  input  logic          avm_readdatavalid,
  output logic          wbuf_wr_en,
  output logic [CW-1:0] wbuf_wr_addr,
  output logic [DW-1:0] wbuf_wr_data
`ifdef WFC_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);

  localparam logic [AW-1:0] STRIDE = AW'(wfc_byte_stride(DW));

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] base_q;
  logic          pending_q;
  logic [CW-1:0] req_cnt;
  logic [CW-1:0] rsp_cnt;
  logic [CW-1:0] outstanding;
  logic          limit_hit;
  logic          start_ok;
  logic          accept;
  logic          fill_window;
  logic          response;

  assign start_ok    = (state == ST_IDLE) && start && !clean;
  assign accept      = avm_read && !avm_waitrequest;
  assign fill_window = (state == ST_REQ) || (state == ST_DRAIN);
  assign response    = avm_readdatavalid && (fill_window || (state == ST_FLUSH));

  wfc_outstanding_tracker #(
    .CW              (CW),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_ok),
    .accept      (accept),
    .response    (response),
    .req_cnt     (req_cnt),
    .rsp_cnt     (rsp_cnt),
    .outstanding (outstanding),
    .limit_hit   (limit_hit)
  );

  // Address follows req_cnt, so it cannot move while a stalled read is pending.
  assign avm_address = base_q + AW'(req_cnt) * STRIDE;

  // In FLUSH only a read already stalled on waitrequest may stay asserted.
  always_comb begin
    avm_read = 1'b0;
    case (state)
      ST_REQ:   avm_read = (req_cnt < CW'(WEIGHT_NUM)) && !limit_hit;
      ST_FLUSH: avm_read = pending_q;
      default:  avm_read = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_REQ;
      ST_REQ: begin
        if (clean)                                          state_nxt = ST_FLUSH;
        else if (accept && req_cnt == CW'(WEIGHT_NUM - 1))  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (clean)                                          state_nxt = ST_FLUSH;
        else if (response && rsp_cnt == CW'(WEIGHT_NUM - 1)) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FLUSH: if (outstanding == '0 && !pending_q) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending_q <= avm_read && avm_waitrequest;
      if (start_ok) base_q <= base_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_wr_en   <= 1'b0;
      wbuf_wr_addr <= '0;
      wbuf_wr_data <= '0;
    end else begin
      wbuf_wr_en <= avm_readdatavalid && fill_window;
      if (avm_readdatavalid && fill_window) begin
        wbuf_wr_addr <= rsp_cnt;
        wbuf_wr_data <= avm_readdata;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

`ifdef WFC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               perf_cycles <= '0;
    else if (start_ok)                     perf_cycles <= '0;
    else if (busy && perf_cycles != '1)    perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: two instances (deep and MAX_OUTSTANDING=2) with latency-model slaves.
module tb_weight_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [31:0] data_of(input logic [31:0] addr);
    return addr ^ 32'hCAFE_0000;
  endfunction

  // instance A: WEIGHT_NUM=4, MAX_OUTSTANDING=8
  logic        start_a = 1'b0, clean_a = 1'b0, wait_a = 1'b0;
  logic [31:0] base_a = '0;
  logic        busy_a, done_a, read_a, wr_en_a;
  logic [31:0] addr_a, wr_data_a;
  logic [15:0] wr_addr_a;
  logic [31:0] rdata_a;
  logic        rvalid_a;
  int          lat_a = 3;
  rsp_t        qa[$];
`ifdef WFC_PERF_CNT_EN
  logic [31:0] perf_a;
`endif

  // instance B: WEIGHT_NUM=8, MAX_OUTSTANDING=2
  logic        start_b = 1'b0, clean_b = 1'b0, wait_b = 1'b0;
  logic [31:0] base_b = '0;
  logic        busy_b, done_b, read_b, wr_en_b;
  logic [31:0] addr_b, wr_data_b;
  logic [15:0] wr_addr_b;
  logic [31:0] rdata_b;
  logic        rvalid_b;
  localparam int LAT_B = 10;
  rsp_t        qb[$];
`ifdef WFC_PERF_CNT_EN
  logic [31:0] perf_b;
`endif

  weight_fetch_ctrl #(.WEIGHT_NUM(4), .MAX_OUTSTANDING(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clean(clean_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .avm_address(addr_a), .avm_read(read_a),
    .avm_waitrequest(wait_a), .avm_readdata(rdata_a), .avm_readdatavalid(rvalid_a),
    .wbuf_wr_en(wr_en_a), .wbuf_wr_addr(wr_addr_a), .wbuf_wr_data(wr_data_a)
`ifdef WFC_PERF_CNT_EN
    , .perf_cycles(perf_a)
`endif
  );

  weight_fetch_ctrl #(.WEIGHT_NUM(8), .MAX_OUTSTANDING(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clean(clean_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wait_b), .avm_readdata(rdata_b), .avm_readdatavalid(rvalid_b),
    .wbuf_wr_en(wr_en_b), .wbuf_wr_addr(wr_addr_b), .wbuf_wr_data(wr_data_b)
`ifdef WFC_PERF_CNT_EN
    , .perf_cycles(perf_b)
`endif
  );

  // fixed-latency in-order slaves: accept in cycle k -> readdatavalid in cycle k+lat
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      rvalid_a <= 1'b0;
      rdata_a  <= '0;
    end else begin
      if (read_a && !wait_a) qa.push_back('{cyc + lat_a, data_of(addr_a)});
      if (qa.size() > 0 && qa[0].due == cyc + 1) begin
        rvalid_a <= 1'b1;
        rdata_a  <= qa[0].data;
        void'(qa.pop_front());
      end else begin
        rvalid_a <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      qb.delete();
      rvalid_b <= 1'b0;
      rdata_b  <= '0;
    end else begin
      if (read_b && !wait_b) qb.push_back('{cyc + LAT_B, data_of(addr_b)});
      if (qb.size() > 0 && qb[0].due == cyc + 1) begin
        rvalid_b <= 1'b1;
        rdata_b  <= qb[0].data;
        void'(qb.pop_front());
      end else begin
        rvalid_b <= 1'b0;
      end
    end
  end

  // monitors
  int          acc_n_a = 0, wr_n_a = 0, done_n_a = 0;
  logic [31:0] acc_log_a [64];
  logic [15:0] wr_addr_log_a [64];
  logic [31:0] wr_data_log_a [64];

  always @(negedge clk) begin
    if (read_a && !wait_a && acc_n_a < 64) begin
      acc_log_a[acc_n_a] <= addr_a;
      acc_n_a            <= acc_n_a + 1;
    end
    if (wr_en_a && wr_n_a < 64) begin
      wr_addr_log_a[wr_n_a] <= wr_addr_a;
      wr_data_log_a[wr_n_a] <= wr_data_a;
      wr_n_a                <= wr_n_a + 1;
    end
    if (done_a) done_n_a <= done_n_a + 1;
  end

  int          acc_n_b = 0, rsp_n_b = 0, wr_n_b = 0, done_n_b = 0;
  int          max_out_b = 0, acc_at_first_b = 0;
  logic        first_seen_b = 1'b0;
  logic [15:0] last_wr_addr_b = '0;
  logic [31:0] last_wr_data_b = '0;

  always @(negedge clk) begin
    if (rvalid_b && !first_seen_b) begin
      acc_at_first_b <= acc_n_b;
      first_seen_b   <= 1'b1;
    end
    acc_n_b <= acc_n_b + ((read_b && !wait_b) ? 1 : 0);
    rsp_n_b <= rsp_n_b + (rvalid_b ? 1 : 0);
    if (acc_n_b + ((read_b && !wait_b) ? 1 : 0) - rsp_n_b - (rvalid_b ? 1 : 0) > max_out_b)
      max_out_b <= acc_n_b + ((read_b && !wait_b) ? 1 : 0) - rsp_n_b - (rvalid_b ? 1 : 0);
    if (wr_en_b) begin
      wr_n_b         <= wr_n_b + 1;
      last_wr_addr_b <= wr_addr_b;
      last_wr_data_b <= wr_data_b;
    end
    if (done_b) done_n_b <= done_n_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a(input logic [31:0] base);
    step();
    base_a  = base;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  // returns at the negedge of the done cycle; c is the cycle index relative to start
  task automatic wait_done_a(input int c0, input int budget, output int c);
    c = c0;
    @(negedge clk);
    while (!done_a && c < budget) begin
      step();
      @(negedge clk);
      c++;
    end
    check("done_a seen", 32'(done_a), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " busy"},         32'(busy_a),    32'd0);
    check({tag, " done"},         32'(done_a),    32'd0);
    check({tag, " avm_read"},     32'(read_a),    32'd0);
    check({tag, " avm_address"},  addr_a,         32'd0);
    check({tag, " wbuf_wr_en"},   32'(wr_en_a),   32'd0);
    check({tag, " wbuf_wr_addr"}, 32'(wr_addr_a), 32'd0);
    check({tag, " wbuf_wr_data"}, wr_data_a,      32'd0);
  endtask

  initial begin
    int c, acc0, wr0, d0, n;

    // reset values
    step();
    @(negedge clk);
    check_reset_a("rst");
    step();
    rst = 1'b0;
    repeat (2) step();

    // basic fetch: 4 words from 0x1000, latency 3
    acc0 = acc_n_a; wr0 = wr_n_a; d0 = done_n_a;
    lat_a = 3;
    pulse_start_a(32'h1000);
    wait_done_a(1, 40, c);
    check("s1 done cycle", c, 32'd8);
    check("s1 last write with done en", 32'(wr_en_a), 32'd1);
    check("s1 last write with done addr", 32'(wr_addr_a), 32'd3);
    step();
    @(negedge clk);
    check("s1 busy after done", 32'(busy_a), 32'd0);
    check("s1 accepts", acc_n_a - acc0, 32'd4);
    check("s1 writes", wr_n_a - wr0, 32'd4);
    check("s1 done pulses", done_n_a - d0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s1 addr %0d", i), acc_log_a[acc0 + i], 32'h1000 + 32'(4 * i));
      check($sformatf("s1 wr addr %0d", i), 32'(wr_addr_log_a[wr0 + i]), 32'(i));
      check($sformatf("s1 wr data %0d", i), wr_data_log_a[wr0 + i], data_of(32'h1000 + 32'(4 * i)));
    end
`ifdef WFC_PERF_CNT_EN
    check("s1 perf_cycles", perf_a, 32'd8);
    repeat (3) step();
    @(negedge clk);
    check("s1 perf_cycles hold", perf_a, 32'd8);
`endif

    // waitrequest held for 5 cycles on the second request
    repeat (2) step();
    acc0 = acc_n_a; wr0 = wr_n_a;
    pulse_start_a(32'h1000);
    step();
    wait_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      @(negedge clk);
      check($sformatf("s2 stall read %0d", i), 32'(read_a), 32'd1);
      check($sformatf("s2 stall addr %0d", i), addr_a, 32'h1004);
    end
    step();
    wait_a = 1'b0;
    wait_done_a(7, 60, c);
    step();
    @(negedge clk);
    check("s2 accepts", acc_n_a - acc0, 32'd4);
    check("s2 writes", wr_n_a - wr0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2 wr addr %0d", i), 32'(wr_addr_log_a[wr0 + i]), 32'(i));
      check($sformatf("s2 wr data %0d", i), wr_data_log_a[wr0 + i], data_of(32'h1000 + 32'(4 * i)));
    end

    // outstanding limit of 2 with 10-cycle latency (instance B)
    step();
    base_b  = 32'h0;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("s3 done_b seen", 32'(done_b), 32'd1);
    step();
    @(negedge clk);
    check("s3 first response seen", 32'(first_seen_b), 32'd1);
    check("s3 accepts before first response", acc_at_first_b, 32'd2);
    check("s3 max outstanding", max_out_b, 32'd2);
    check("s3 writes", wr_n_b, 32'd8);
    check("s3 last wr addr", 32'(last_wr_addr_b), 32'd7);
    check("s3 last wr data", last_wr_data_b, data_of(32'h1C));
    check("s3 done pulses", done_n_b, 32'd1);
    check("s3 busy after", 32'(busy_b), 32'd0);

    // clean during REQ with 3 outstanding
    acc0 = acc_n_a; wr0 = wr_n_a; d0 = done_n_a;
    lat_a = 10;
    pulse_start_a(32'h1000);
    step();
    step();
    clean_a = 1'b1;
    step();
    clean_a = 1'b0;
    c = 4;
    @(negedge clk);
    while (busy_a && c < 60) begin
      step();
      @(negedge clk);
      c++;
    end
    check("s4 flush exit cycle", c, 32'd15);
    step();
    @(negedge clk);
    check("s4 accepts", acc_n_a - acc0, 32'd3);
    check("s4 discarded writes", wr_n_a - wr0, 32'd0);
    check("s4 no done", done_n_a - d0, 32'd0);
    check("s4 read idle", 32'(read_a), 32'd0);
    acc0 = acc_n_a; wr0 = wr_n_a; d0 = done_n_a;
    lat_a = 3;
    pulse_start_a(32'h0);
    wait_done_a(1, 40, c);
    step();
    @(negedge clk);
    check("s4 refetch accepts", acc_n_a - acc0, 32'd4);
    check("s4 refetch writes", wr_n_a - wr0, 32'd4);
    check("s4 refetch done", done_n_a - d0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s4 refetch addr %0d", i), acc_log_a[acc0 + i], 32'(4 * i));
      check($sformatf("s4 refetch wr addr %0d", i), 32'(wr_addr_log_a[wr0 + i]), 32'(i));
      check($sformatf("s4 refetch wr data %0d", i), wr_data_log_a[wr0 + i], data_of(32'(4 * i)));
    end

    // start together with clean in IDLE is ignored
    acc0 = acc_n_a;
    step();
    base_a  = 32'h5000;
    start_a = 1'b1;
    clean_a = 1'b1;
    step();
    start_a = 1'b0;
    clean_a = 1'b0;
    @(negedge clk);
    check("s5 start+clean busy", 32'(busy_a), 32'd0);
    check("s5 start+clean read", 32'(read_a), 32'd0);
    step();
    @(negedge clk);
    check("s5 start+clean accepts", acc_n_a - acc0, 32'd0);

    // start while busy is ignored
    acc0 = acc_n_a; d0 = done_n_a;
    pulse_start_a(32'h2000);
    step();
    base_a  = 32'h3000;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done_a(3, 40, c);
    step();
    @(negedge clk);
    check("s5 busy start accepts", acc_n_a - acc0, 32'd4);
    check("s5 busy start last addr", acc_log_a[acc0 + 3], 32'h200C);
    check("s5 busy start done", done_n_a - d0, 32'd1);
    repeat (2) step();
    @(negedge clk);
    check("s5 no restart", 32'(busy_a), 32'd0);

    // reset in the middle of DRAIN
    lat_a = 10;
    pulse_start_a(32'h4000);
    repeat (4) step();
    @(negedge clk);
    check("s5 in drain busy", 32'(busy_a), 32'd1);
    check("s5 in drain read", 32'(read_a), 32'd0);
    step();
    rst = 1'b1;
    #1;
    check_reset_a("midrst");
    repeat (2) step();
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
